// File: rtl/wb_master_bridge_if.sv
// -----------------------------------------------------------------------------
// wb_master_bridge_if
//
// Groups the request channel, response channel and Wishbone classic initiator
// signals of wb_master_bridge into a single bundle.
//
// Signal groups (names follow the bridge's point of view):
//   req_*   : core-side request channel (valid/ready), into the bridge
//   rsp_*   : core-side response channel (valid/ready), out of the bridge
//   wb_*    : Wishbone classic initiator port toward the uncore slaves
//
// Modports:
//   master : the bridge itself (consumes requests, drives the Wishbone bus)
//   slave  : the environment around the bridge (request agent, response
//            consumer and Wishbone slave collapsed into one view)
// -----------------------------------------------------------------------------
interface wb_master_bridge_if #(
    parameter int unsigned aw = 32,
    parameter int unsigned dw = 32
);
    // Request channel
    logic            req_valid_i;
    logic            req_ready_o;
    logic            req_we_i;
    logic [aw-1:0]   req_addr_i;
    logic [dw-1:0]   req_wdata_i;
    logic [dw/8-1:0] req_be_i;

    // Response channel
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [dw-1:0]   rsp_rdata_o;
    logic            rsp_err_o;

    // Wishbone classic initiator
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_we_o;
    logic [aw-1:0]   wb_adr_o;
    logic [dw-1:0]   wb_dat_o;
    logic [dw/8-1:0] wb_sel_o;
    logic [dw-1:0]   wb_dat_i;
    logic            wb_ack_i;
    logic            wb_err_i;

    modport master (
        input  req_valid_i,
        output req_ready_o,
        input  req_we_i,
        input  req_addr_i,
        input  req_wdata_i,
        input  req_be_i,
        output rsp_valid_o,
        input  rsp_ready_i,
        output rsp_rdata_o,
        output rsp_err_o,
        output wb_cyc_o,
        output wb_stb_o,
        output wb_we_o,
        output wb_adr_o,
        output wb_dat_o,
        output wb_sel_o,
        input  wb_dat_i,
        input  wb_ack_i,
        input  wb_err_i
    );

    modport slave (
        output req_valid_i,
        input  req_ready_o,
        output req_we_i,
        output req_addr_i,
        output req_wdata_i,
        output req_be_i,
        input  rsp_valid_o,
        output rsp_ready_i,
        input  rsp_rdata_o,
        input  rsp_err_o,
        input  wb_cyc_o,
        input  wb_stb_o,
        input  wb_we_o,
        input  wb_adr_o,
        input  wb_dat_o,
        input  wb_sel_o,
        output wb_dat_i,
        output wb_ack_i,
        output wb_err_i
    );

endinterface

// File: rtl/wb_master_bridge.sv
// -----------------------------------------------------------------------------
// wb_master_bridge
//
// Single-outstanding Wishbone classic initiator. A request accepted on the
// valid/ready request channel becomes exactly one Wishbone read or write
// cycle; its outcome (read data, or an error) is returned on the valid/ready
// response channel. A programmable bus timeout turns a hung slave into an
// error response.
//
// Parameters:
//   aw      : address width
//   dw      : data width (32; byte-select width is dw/8)
//   TIMEOUT : stb cycles without ack/err before a forced error; 0 = never
//
// Ports:
//   wb_clk_i  : clock
//   wb_rst_ni : asynchronous active-low reset
//   bus_io    : wb_master_bridge_if.master
//               req_*  request channel   (req_ready_o = idle)
//               rsp_*  response channel  (registered, held until consumed)
//               wb_*   Wishbone initiator (all outputs registered)
//
// Timing against a slave that acks combinationally in the first stb cycle:
// request handshake at edge N, cyc/stb high for cycle N+1, response valid in
// cycle N+2 with cyc/stb already low; one transaction every 3 cycles at best.
// -----------------------------------------------------------------------------
module wb_master_bridge #(
    parameter int unsigned aw      = 32,
    parameter int unsigned dw      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    wb_master_bridge_if.master    bus_io
);

    // Counter is wide enough to hold TIMEOUT; kept at one bit when disabled.
    localparam int unsigned CntW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TimeoutLast = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutLast);

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StResp
    } state_e;

    state_e              state_q;
    logic [CntW-1:0]     cnt_q;

    logic                cyc_q;
    logic                stb_q;
    logic                we_q;
    logic [aw-1:0]       adr_q;
    logic [dw-1:0]       dat_q;
    logic [dw/8-1:0]     sel_q;

    logic                rsp_valid_q;
    logic [dw-1:0]       rsp_rdata_q;
    logic                rsp_err_q;

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.req_valid_i) begin
                        we_q    <= bus_io.req_we_i;
                        adr_q   <= bus_io.req_addr_i;
                        dat_q   <= bus_io.req_wdata_i;
                        sel_q   <= bus_io.req_be_i;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StBus;
                    end
                end

                StBus: begin
                    if (bus_io.wb_err_i) begin
                        // Error termination takes priority over a coincident ack.
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        state_q     <= StResp;
                    end else if (bus_io.wb_ack_i) begin
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= we_q ? '0 : bus_io.wb_dat_i;
                        state_q     <= StResp;
                    end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
                        // Slave never answered: abandon the cycle and report error.
                        // Leaving here is also what keeps the counter from wrapping.
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        state_q     <= StResp;
                    end else if (TIMEOUT != 0) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end

                StResp: begin
                    // Returning to idle first means a new request waits one cycle.
                    if (bus_io.rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus_io.req_ready_o = (state_q == StIdle);

    assign bus_io.rsp_valid_o = rsp_valid_q;
    assign bus_io.rsp_rdata_o = rsp_rdata_q;
    assign bus_io.rsp_err_o   = rsp_err_q;

    assign bus_io.wb_cyc_o    = cyc_q;
    assign bus_io.wb_stb_o    = stb_q;
    assign bus_io.wb_we_o     = we_q;
    assign bus_io.wb_adr_o    = adr_q;
    assign bus_io.wb_dat_o    = dat_q;
    assign bus_io.wb_sel_o    = sel_q;

endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
Single-outstanding Wishbone classic initiator. Converts a valid/ready request from a core-side agent (CPU load/store unit, debug module) into one Wishbone read or write cycle toward uncore slaves such as the GPIO block. It returns read data, or an error, on a valid/ready response channel. A programmable bus timeout converts a hung slave into an error response.

Parameters:
aw, 32, Wishbone/request address width
dw, 32, data width (fixed to 32; sel width = dw/8)
TIMEOUT, 255, cycles with stb high and no ack/err before forced error; 0 disables timeout

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  asynchronous reset, active-low
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_we_i  in  1  1=write, 0=read
req_addr_i  in  aw  byte address
req_wdata_i  in  dw  write data
req_be_i  in  4  byte enables
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_rdata_o  out  dw  read data (0 for writes/errors)
rsp_err_o  out  1  1 = bus error or timeout
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  Wishbone write enable
wb_adr_o  out  aw  Wishbone address
wb_dat_o  out  dw  Wishbone write data
wb_sel_o  out  4  Wishbone byte selects
wb_dat_i  in  dw  Wishbone read data
wb_ack_i  in  1  Wishbone normal termination
wb_err_i  in  1  Wishbone error termination

Behaviour:
- Clock wb_clk_i; reset wb_rst_ni asynchronous, active-low. All state and registered outputs clear immediately on assertion.
- Reset values: state IDLE; wb_cyc_o/wb_stb_o/wb_we_o=0; wb_adr_o/wb_dat_o=0; wb_sel_o=0; rsp_valid_o=0; rsp_rdata_o=0; rsp_err_o=0; timeout counter=0.
- All Wishbone outputs are registered. req_ready_o = (state==IDLE); it is combinational from state only.
- FSM:
  - IDLE: on req_valid_i, latch we/addr/wdata/be into the wb_* outputs, set cyc=stb=1, clear counter, go to BUS.
  - BUS: hold cyc/stb/adr/dat/sel/we stable.
    - Sample wb_ack_i/wb_err_i at each rising edge.
    - On ack or err: drop cyc/stb, set rsp_valid_o=1, go to RESP.
    - rsp_err_o = wb_err_i. rsp_rdata_o = wb_dat_i only if read and ack without err; otherwise 0.
    - ack and err in the same cycle: err wins.
    - Otherwise increment the counter. If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no termination: drop cyc/stb, rsp_err_o=1, rsp_rdata_o=0, go to RESP.
  - RESP: hold rsp_* stable until rsp_ready_i. On handshake, clear rsp_valid_o and go to IDLE. A new request cannot be accepted in this same cycle.
- Latency against a combinational-ack slave:
  - request handshake at edge N;
  - cyc/stb high during cycle N+1;
  - ack sampled at edge N+1;
  - rsp_valid_o high in cycle N+2 with cyc/stb already low.
  - Minimum throughput: one transaction per 3 cycles with rsp_ready_i held high.
- Bus stalls: wb_ack_i/wb_err_i arriving while in IDLE or RESP are ignored.
- Timeout: counter width is clog2(TIMEOUT+1). The counter never wraps; it saturates at TIMEOUT-1 by leaving BUS.
- Reset mid-operation (BUS or RESP): the cycle is abandoned, cyc/stb fall asynchronously, and no response is issued after reset release.
- req_* inputs are ignored outside IDLE. The request agent must hold them stable only until its handshake.

Test Plan:
- Write: req we=1, addr=0x4, wdata=0xA5A5_0000, be=4'b1100; slave acks in the first stb cycle -> wb_sel_o=4'b1100 and wb_adr_o=0x4 during that cycle; rsp_valid_o next cycle with rsp_err_o=0, rsp_rdata_o=0; total 3 cycles.
- Read with wait states: addr=0x0, slave asserts ack after 3 stb cycles with wb_dat_i=0x1234_5678 -> cyc/stb stay high exactly 3 cycles; rsp_rdata_o=0x1234_5678, rsp_err_o=0.
- Error: slave asserts ack and err together on a read with wb_dat_i=0xFFFF_FFFF -> rsp_err_o=1, rsp_rdata_o=0.
- Timeout: TIMEOUT=8, slave never responds -> stb high for exactly 8 cycles, then rsp_err_o=1; a subsequent request completes normally.
- Backpressure: rsp_ready_i held low 5 cycles, req_valid_i held high -> req_ready_o=0 and rsp_* stable throughout; second request accepted only the cycle after the response handshake.
- Reset mid-BUS: drive wb_rst_ni low while stb=1 -> cyc/stb/rsp_valid_o go to 0 asynchronously; after release, state is IDLE and req_ready_o=1.
